// File: rtl/mvu_job_sched.sv
// Host-side MVU job scheduler: an in-order job FIFO, per-MVU start/done/timeout
// trackers, sticky irqs and a round-robin completion return port.
module mvu_job_sched #(
    parameter int NMVU       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BTAG       = 8,
    parameter int BTIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [$clog2(NMVU)-1:0] job_mvu,
    input  logic [BTAG-1:0]         job_tag,
    input  logic [BTIMEOUT-1:0]     timeout_cycles,
    output logic [NMVU-1:0]         start,
    input  logic [NMVU-1:0]         done,
    output logic [NMVU-1:0]         busy,
    output logic [NMVU-1:0]         irq,
    input  logic [NMVU-1:0]         irq_ack,
    output logic                    cmpl_valid,
    input  logic                    cmpl_ready,
    output logic [$clog2(NMVU)-1:0] cmpl_mvu,
    output logic [BTAG-1:0]         cmpl_tag,
    output logic                    cmpl_timeout
);

    localparam int MW = $clog2(NMVU);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [MW:0] NMVU_L  = (MW+1)'(NMVU);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [MW-1:0]       fifo_mvu [FIFO_DEPTH];
    logic [BTAG-1:0]     fifo_tag [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count_q;
    logic [MW-1:0]       head_mvu;
    logic [BTAG-1:0]     head_tag;
    logic                push, pop;

    logic [NMVU-1:0]     start_q, busy_q, pend_q, to_q, irq_q;
    logic [NMVU-1:0]     disp_vec, fin_done, fin_to, fin, cmpl_clr;
    logic [BTAG-1:0]     tag_q   [NMVU];
    logic [BTIMEOUT-1:0] limit_q [NMVU];
    logic [BTIMEOUT-1:0] timer_q [NMVU];

    logic [MW-1:0]       rr_q;
    logic [MW-1:0]       cand;
    logic [MW-1:0]       arb_idx;
    logic                arb_found;

    assign job_ready = (count_q != DEPTH_L);
    assign head_mvu  = fifo_mvu[rd_ptr];
    assign head_tag  = fifo_tag[rd_ptr];

    // Out-of-range targets are accepted on the handshake but never stored.
    assign push = job_valid && job_ready && ({1'b0, job_mvu} < NMVU_L);
    assign pop  = (count_q != '0) && !busy_q[head_mvu] && !pend_q[head_mvu];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mvu[wr_ptr] <= job_mvu;
            fifo_tag[wr_ptr] <= job_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        disp_vec = '0;
        if (pop)
            disp_vec[head_mvu] = 1'b1;
    end

    // done is masked in the start cycle; a done coinciding with expiry wins.
    always_comb begin
        fin_done = '0;
        fin_to   = '0;
        for (int i = 0; i < NMVU; i++) begin
            fin_done[i] = busy_q[i] && !start_q[i] && done[i];
            fin_to[i]   = busy_q[i] && !fin_done[i] && (limit_q[i] != '0) &&
                          (timer_q[i] == limit_q[i]);
        end
        fin = fin_done | fin_to;
    end

    always_comb begin
        cmpl_clr = '0;
        if (cmpl_valid && cmpl_ready)
            cmpl_clr[cmpl_mvu] = 1'b1;
    end

    // Timer reads 1 in the start cycle, so a limit of N expires in cycle start+N-1.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NMVU; i++) begin
            if (disp_vec[i]) begin
                tag_q[i]   <= head_tag;
                limit_q[i] <= timeout_cycles;
                timer_q[i] <= BTIMEOUT'(1);
            end else begin
                timer_q[i] <= timer_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
            to_q    <= '0;
            irq_q   <= '0;
        end else begin
            start_q <= disp_vec;
            busy_q  <= (busy_q & ~fin) | disp_vec;
            pend_q  <= (pend_q & ~cmpl_clr) | fin;
            to_q    <= (to_q & ~fin) | fin_to;
            irq_q   <= (irq_q & ~irq_ack) | fin;
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NMVU; k++) begin
            cand = MW'((int'(rr_q) + k) % NMVU);
            if (!arb_found && pend_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // A record is only loaded while the port is empty, so pend of the
    // in-flight MVU cannot be picked twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmpl_valid   <= 1'b0;
            cmpl_mvu     <= '0;
            cmpl_tag     <= '0;
            cmpl_timeout <= 1'b0;
            rr_q         <= '0;
        end else if (cmpl_valid) begin
            if (cmpl_ready) begin
                cmpl_valid <= 1'b0;
                rr_q       <= (cmpl_mvu == MW'(NMVU - 1)) ? '0 : cmpl_mvu + 1'b1;
            end
        end else if (arb_found) begin
            cmpl_valid   <= 1'b1;
            cmpl_mvu     <= arb_idx;
            cmpl_tag     <= tag_q[arb_idx];
            cmpl_timeout <= to_q[arb_idx];
        end
    end

    assign start = start_q;
    assign busy  = busy_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mvu_job_sched.sv
// Directed bench for mvu_job_sched: single job, FIFO full, head-of-line
// blocking, timeout, round-robin completions, reset mid-job, start-cycle done.
module tb_mvu_job_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [2:0]  job_mvu;
    logic [7:0]  job_tag;
    logic [15:0] timeout_cycles;
    logic [7:0]  start;
    logic [7:0]  done;
    logic [7:0]  busy;
    logic [7:0]  irq;
    logic [7:0]  irq_ack;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [2:0]  cmpl_mvu;
    logic [7:0]  cmpl_tag;
    logic        cmpl_timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] saw_start;
    logic       saw_cmpl;

    mvu_job_sched #(
        .NMVU(8), .FIFO_DEPTH(4), .BTAG(8), .BTIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_mvu(job_mvu), .job_tag(job_tag), .timeout_cycles(timeout_cycles),
        .start(start), .done(done), .busy(busy),
        .irq(irq), .irq_ack(irq_ack),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_mvu(cmpl_mvu), .cmpl_tag(cmpl_tag), .cmpl_timeout(cmpl_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] m, input logic [7:0] t);
        job_valid = v;
        job_mvu   = m;
        job_tag   = t;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 3'd0, 8'h00);
        timeout_cycles = 16'd0;
        done           = 8'h00;
        irq_ack        = 8'h00;
        cmpl_ready     = 1'b0;
        rst            = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic waitCmpl();
        int n = 0;
        while (!cmpl_valid && n < 60) begin
            nextCycle();
            n++;
        end
        checkOutput("cmpl_wait", 32'(cmpl_valid), 32'd1);
    endtask

    task automatic waitRunning(input int m);
        int n = 0;
        while (!(busy[m] && !start[m]) && n < 60) begin
            nextCycle();
            n++;
        end
        checkOutput("run_wait", 32'(busy[m]), 32'd1);
    endtask

    task automatic ackCmpl();
        cmpl_ready = 1'b1;
        nextCycle();
        cmpl_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nextCycle();
        resetDut();
        checkOutput("rst_start",     32'(start),        32'h0);
        checkOutput("rst_busy",      32'(busy),         32'h0);
        checkOutput("rst_irq",       32'(irq),          32'h0);
        checkOutput("rst_cvalid",    32'(cmpl_valid),   32'h0);
        checkOutput("rst_cmvu",      32'(cmpl_mvu),     32'h0);
        checkOutput("rst_ctag",      32'(cmpl_tag),     32'h0);
        checkOutput("rst_cto",       32'(cmpl_timeout), 32'h0);
        checkOutput("rst_job_ready", 32'(job_ready),    32'h1);

        // T1 single job
        applyStimulus(1'b1, 3'd2, 8'h5A);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        checkOutput("t1_start_early", 32'(start), 32'h00);
        nextCycle();
        checkOutput("t1_start", 32'(start), 32'h04);
        checkOutput("t1_busy",  32'(busy),  32'h04);
        nextCycle();
        checkOutput("t1_start_pulse", 32'(start), 32'h00);
        checkOutput("t1_busy_hold",   32'(busy),  32'h04);
        nextCycle();
        nextCycle();
        nextCycle();
        done = 8'h04;
        nextCycle();
        done = 8'h00;
        checkOutput("t1_busy_clr",  32'(busy),       32'h00);
        checkOutput("t1_irq_set",   32'(irq),        32'h04);
        checkOutput("t1_cvalid_lo", 32'(cmpl_valid), 32'h0);
        nextCycle();
        checkOutput("t1_cvalid", 32'(cmpl_valid),   32'h1);
        checkOutput("t1_cmvu",   32'(cmpl_mvu),     32'h2);
        checkOutput("t1_ctag",   32'(cmpl_tag),     32'h5A);
        checkOutput("t1_cto",    32'(cmpl_timeout), 32'h0);
        ackCmpl();
        checkOutput("t1_cvalid_gone", 32'(cmpl_valid), 32'h0);
        checkOutput("t1_irq_sticky",  32'(irq),        32'h04);
        irq_ack = 8'h04;
        nextCycle();
        irq_ack = 8'h00;
        checkOutput("t1_irq_ack", 32'(irq), 32'h00);

        // T2 FIFO full: job 0x20 runs on MVU 0, 0x21..0x24 fill the FIFO, 0x25 is refused
        resetDut();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 3'd0, 8'(8'h20 + k));
            checkOutput("t2_ready", 32'(job_ready), (k < 5) ? 32'd1 : 32'd0);
            nextCycle();
        end
        checkOutput("t2_ready_full", 32'(job_ready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            waitRunning(0);
            done = 8'h01;
            nextCycle();
            done = 8'h00;
            waitCmpl();
            checkOutput("t2_cmvu", 32'(cmpl_mvu), 32'h0);
            checkOutput("t2_ctag", 32'(cmpl_tag), 32'h20 + k);
            ackCmpl();
            irq_ack = 8'h01;
            nextCycle();
            irq_ack = 8'h00;
            checkOutput("t2_ready_drain", 32'(job_ready), 32'd1);
        end
        repeat (5) nextCycle();
        checkOutput("t2_busy_end",  32'(busy),       32'h00);
        checkOutput("t2_cvalid_end", 32'(cmpl_valid), 32'h0);

        // T3 head-of-line: m1 job waits behind a queued m0 job
        resetDut();
        applyStimulus(1'b1, 3'd0, 8'h30);
        nextCycle();
        applyStimulus(1'b1, 3'd0, 8'h31);
        nextCycle();
        applyStimulus(1'b1, 3'd1, 8'h32);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        saw_start = 8'h00;
        repeat (6) begin
            saw_start = saw_start | start;
            nextCycle();
        end
        checkOutput("t3_hol_blocked", 32'(saw_start), 32'h00);
        done = 8'h01;
        nextCycle();
        done = 8'h00;
        waitCmpl();
        checkOutput("t3_ctag", 32'(cmpl_tag), 32'h30);
        ackCmpl();
        checkOutput("t3_start_h1", 32'(start), 32'h00);
        nextCycle();
        checkOutput("t3_start_m0", 32'(start), 32'h01);
        nextCycle();
        checkOutput("t3_start_m1", 32'(start), 32'h02);

        // T4 timeout of 10 sampled at dispatch, later change to 3 has no effect
        resetDut();
        timeout_cycles = 16'd10;
        applyStimulus(1'b1, 3'd7, 8'h47);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        nextCycle();
        timeout_cycles = 16'd3;
        checkOutput("t4_start", 32'(start), 32'h80);
        repeat (9) nextCycle();
        checkOutput("t4_busy_s9", 32'(busy), 32'h80);
        nextCycle();
        checkOutput("t4_busy_s10",   32'(busy),       32'h00);
        checkOutput("t4_cvalid_s10", 32'(cmpl_valid), 32'h0);
        nextCycle();
        checkOutput("t4_cvalid_s11", 32'(cmpl_valid),   32'h1);
        checkOutput("t4_cmvu",       32'(cmpl_mvu),     32'h7);
        checkOutput("t4_ctag",       32'(cmpl_tag),     32'h47);
        checkOutput("t4_cto",        32'(cmpl_timeout), 32'h1);
        ackCmpl();
        irq_ack = 8'h80;
        nextCycle();
        irq_ack = 8'h00;
        done = 8'h80;
        nextCycle();
        done = 8'h00;
        repeat (3) nextCycle();
        checkOutput("t4_late_done_irq",    32'(irq),        32'h00);
        checkOutput("t4_late_done_cvalid", 32'(cmpl_valid), 32'h0);
        timeout_cycles = 16'd0;

        // T5 round-robin: simultaneous done on 1,3,6 with a stalled port
        resetDut();
        applyStimulus(1'b1, 3'd1, 8'h51);
        nextCycle();
        applyStimulus(1'b1, 3'd3, 8'h53);
        nextCycle();
        applyStimulus(1'b1, 3'd6, 8'h56);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        nextCycle();
        nextCycle();
        checkOutput("t5_busy", 32'(busy), 32'h4A);
        done = 8'h4A;
        nextCycle();
        done = 8'h00;
        checkOutput("t5_irq", 32'(irq), 32'h4A);
        waitCmpl();
        checkOutput("t5_first_mvu", 32'(cmpl_mvu), 32'h1);
        checkOutput("t5_first_tag", 32'(cmpl_tag), 32'h51);
        repeat (5) begin
            nextCycle();
            checkOutput("t5_stall_valid", 32'(cmpl_valid), 32'h1);
            checkOutput("t5_stall_mvu",   32'(cmpl_mvu),   32'h1);
            checkOutput("t5_stall_tag",   32'(cmpl_tag),   32'h51);
        end
        ackCmpl();
        waitCmpl();
        checkOutput("t5_second_mvu", 32'(cmpl_mvu), 32'h3);
        checkOutput("t5_second_tag", 32'(cmpl_tag), 32'h53);
        ackCmpl();
        waitCmpl();
        checkOutput("t5_third_mvu", 32'(cmpl_mvu), 32'h6);
        checkOutput("t5_third_tag", 32'(cmpl_tag), 32'h56);
        ackCmpl();
        // pointer now sits at 7: a tie between MVU 0 and 7 must serve 7 first
        applyStimulus(1'b1, 3'd0, 8'h50);
        nextCycle();
        applyStimulus(1'b1, 3'd7, 8'h57);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        nextCycle();
        nextCycle();
        checkOutput("t5_wrap_busy", 32'(busy), 32'h81);
        done = 8'h81;
        nextCycle();
        done = 8'h00;
        waitCmpl();
        checkOutput("t5_wrap_first",  32'(cmpl_mvu), 32'h7);
        ackCmpl();
        waitCmpl();
        checkOutput("t5_wrap_second", 32'(cmpl_mvu), 32'h0);
        ackCmpl();

        // T6 reset while MVU 4 is busy with two jobs queued behind it
        resetDut();
        applyStimulus(1'b1, 3'd4, 8'h64);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 8'h65);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 8'h66);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        checkOutput("t6_busy_pre", 32'(busy), 32'h10);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("t6_start",     32'(start),      32'h00);
        checkOutput("t6_busy",      32'(busy),       32'h00);
        checkOutput("t6_irq",       32'(irq),        32'h00);
        checkOutput("t6_cvalid",    32'(cmpl_valid), 32'h0);
        checkOutput("t6_job_ready", 32'(job_ready),  32'h1);
        saw_start = 8'h00;
        saw_cmpl  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            done = (k % 2 == 0) ? 8'h10 : 8'h00;
            saw_start = saw_start | start;
            saw_cmpl  = saw_cmpl | cmpl_valid;
            nextCycle();
        end
        done = 8'h00;
        checkOutput("t6_no_start", 32'(saw_start), 32'h00);
        checkOutput("t6_no_cmpl",  32'(saw_cmpl),  32'h0);

        // T7 done asserted during the start cycle is ignored
        resetDut();
        applyStimulus(1'b1, 3'd5, 8'h75);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00);
        nextCycle();
        checkOutput("t7_start", 32'(start), 32'h20);
        done = 8'h20;
        nextCycle();
        done = 8'h00;
        checkOutput("t7_busy_kept", 32'(busy), 32'h20);
        nextCycle();
        nextCycle();
        checkOutput("t7_no_cmpl", 32'(cmpl_valid), 32'h0);
        checkOutput("t7_no_irq",  32'(irq),        32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
